// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state codes and light encodings for the two-road
// intersection controller (traffic_light_fsm and its sub-module).
//   state_e : 3-bit state code, also exported on the State debug port
//   RED/YELLOW/GREEN : {R,Y,G} one-hot signal-head encodings
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_1   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_2   = 3'd5,
        WALK        = 3'd6
    } state_e;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

endpackage

// File: rtl/traffic_light_fsm_sec_tick.sv
// sec_tick: turns the divider's OneHz square wave into a one-clk tick per
// edge (both rising and falling edges count as one elapsed second).
//   clk      in  : system clock
//   rst_n    in  : asynchronous active-low reset
//   one_hz_i in  : divider square wave, synchronous to clk
//   tick_o   out : high for one clk cycle after each one_hz_i edge
module sec_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic one_hz_i,
    output logic tick_o
);

    logic one_hz_q;

    // Resets to 1 to match the divider's power-up level, so leaving reset
    // does not fabricate a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) one_hz_q <= 1'b1;
        else        one_hz_q <= one_hz_i;
    end

    assign tick_o = one_hz_i ^ one_hz_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: main/side road intersection controller. Main road rests
// on green until the side sensor (or a pending pedestrian request) asks for
// service; phases are counted in OneHz edges.
// Optional feature macro: PED_REQ_EN (adds Ped_Req port and the WALK phase).
//   clk          in  : system clock
//   Sync_Reset_n in  : asynchronous active-low reset
//   OneHz        in  : divider output, each edge is one second
//   Side_Car     in  : side-road vehicle sensor (level)
//   Ped_Req      in  : pedestrian request (only with PED_REQ_EN)
//   Main_Lights  out : main head {R,Y,G}
//   Side_Lights  out : side head {R,Y,G}
//   Walk         out : pedestrian walk lamp
//   State        out : current state code
//   Sec_Left     out : seconds remaining in phase, minus 1
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int T_MAIN_GREEN = 20,
    parameter int T_SIDE_GREEN = 10,
    parameter int T_YELLOW     = 3,
    parameter int T_ALL_RED    = 1,
    parameter int T_WALK       = 8,
    parameter int CNT_W        = 6
) (
    input  logic             clk,
    input  logic             Sync_Reset_n,
    input  logic             OneHz,
    input  logic             Side_Car,
`ifdef PED_REQ_EN
    input  logic             Ped_Req,
`endif
    output logic [2:0]       Main_Lights,
    output logic [2:0]       Side_Lights,
    output logic             Walk,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] Sec_Left
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic             ped_pending;

    sec_tick u_sec_tick (
        .clk      (clk),
        .rst_n    (Sync_Reset_n),
        .one_hz_i (OneHz),
        .tick_o   (tick)
    );

    // Counter preload on entry: duration minus one, so a state lasts T ticks.
    function automatic logic [CNT_W-1:0] dur_m1(input state_e s);
        case (s)
            MAIN_GREEN:               dur_m1 = CNT_W'(T_MAIN_GREEN - 1);
            MAIN_YELLOW, SIDE_YELLOW: dur_m1 = CNT_W'(T_YELLOW - 1);
            SIDE_GREEN:               dur_m1 = CNT_W'(T_SIDE_GREEN - 1);
            WALK:                     dur_m1 = CNT_W'(T_WALK - 1);
            default:                  dur_m1 = CNT_W'(T_ALL_RED - 1);
        endcase
    endfunction

    always_ff @(posedge clk or negedge Sync_Reset_n) begin
        if (!Sync_Reset_n) begin
            state_q <= ALL_RED_2;
            cnt_q   <= CNT_W'(T_ALL_RED - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                case (state_q)
                    // Side_Car is only looked at here, on the deciding tick;
                    // failing the test leaves the counter parked at 0.
                    MAIN_GREEN:  if (Side_Car || ped_pending) state_d = MAIN_YELLOW;
                    MAIN_YELLOW: state_d = ALL_RED_1;
                    ALL_RED_1:   state_d = ped_pending ? WALK : SIDE_GREEN;
                    SIDE_GREEN:  state_d = SIDE_YELLOW;
                    SIDE_YELLOW: state_d = ALL_RED_2;
                    WALK:        state_d = ALL_RED_2;
                    default:     state_d = MAIN_GREEN;
                endcase
                if (state_d != state_q) cnt_d = dur_m1(state_d);
            end
        end
    end

`ifdef PED_REQ_EN
    logic ped_pending_q, ped_pending_d;

    // Entry into WALK wins over a same-cycle request, so that request is
    // consumed by the walk phase now starting.
    always_comb begin
        ped_pending_d = ped_pending_q | Ped_Req;
        if (state_d == WALK && state_q != WALK) ped_pending_d = 1'b0;
    end

    always_ff @(posedge clk or negedge Sync_Reset_n) begin
        if (!Sync_Reset_n) ped_pending_q <= 1'b0;
        else               ped_pending_q <= ped_pending_d;
    end

    assign ped_pending = ped_pending_q;
`else
    assign ped_pending = 1'b0;
`endif

    // Moore decode: everything not explicitly green/yellow shows red.
    always_comb begin
        Main_Lights = RED;
        Side_Lights = RED;
        case (state_q)
            MAIN_GREEN:  Main_Lights = GREEN;
            MAIN_YELLOW: Main_Lights = YELLOW;
            SIDE_GREEN:  Side_Lights = GREEN;
            SIDE_YELLOW: Side_Lights = YELLOW;
            default:     ;
        endcase
    end

`ifdef PED_REQ_EN
    assign Walk = (state_q == WALK);
`else
    assign Walk = 1'b0;
`endif

    assign State    = state_q;
    assign Sec_Left = cnt_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
module tb_traffic_light_fsm;

    localparam int TMG = 20, TSG = 10, TY = 3, TAR = 1, TW = 8, CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          one_hz = 1'b1;
    logic          side_car = 1'b0;
`ifdef PED_REQ_EN
    logic          ped_req = 1'b0;
`endif
    logic [2:0]    main_l, side_l, state;
    logic          walk;
    logic [CW-1:0] sec_left;

    int runs = 0;
    int fails = 0;

    // Reference model: phase index (0..6 using the published state codes),
    // ticks already spent in the phase, pedestrian request pending.
    int m_ph, m_el;
    bit m_ped;

    always #5 clk = ~clk;

    traffic_light_fsm #(
        .T_MAIN_GREEN(TMG), .T_SIDE_GREEN(TSG), .T_YELLOW(TY),
        .T_ALL_RED(TAR), .T_WALK(TW), .CNT_W(CW)
    ) dut (
        .clk          (clk),
        .Sync_Reset_n (rst_n),
        .OneHz        (one_hz),
        .Side_Car     (side_car),
`ifdef PED_REQ_EN
        .Ped_Req      (ped_req),
`endif
        .Main_Lights  (main_l),
        .Side_Lights  (side_l),
        .Walk         (walk),
        .State        (state),
        .Sec_Left     (sec_left)
    );

    logic [15:0] act_vec;
    assign act_vec = {state, main_l, side_l, walk, sec_left};

    function automatic int dur(input int ph);
        case (ph)
            0: return TMG;
            1: return TY;
            3: return TSG;
            4: return TY;
            6: return TW;
            default: return TAR;
        endcase
    endfunction

    function automatic int succ(input int ph, input bit ped);
        case (ph)
            0: return 1;
            1: return 2;
            2: return ped ? 6 : 3;
            3: return 4;
            4: return 5;
            6: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] exp_vec();
        logic [2:0] ml, sl;
        int s;
        ml = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
        sl = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
        s  = dur(m_ph) - 1 - m_el;
        return {3'(m_ph), ml, sl, (m_ph == 6), CW'(s)};
    endfunction

    task automatic model_reset();
        m_ph = 5; m_el = 0; m_ped = 0;
    endtask

    // A phase of length T ends on its T-th tick; main green only ends if
    // somebody is asking, otherwise it sits on its last second.
    task automatic model_tick(input bit side);
        int nph;
        if (m_el + 1 >= dur(m_ph)) begin
            if (!(m_ph == 0 && !(side || m_ped))) begin
                nph = succ(m_ph, m_ped);
                if (nph == 6) m_ped = 0;
                m_ph = nph;
                m_el = 0;
            end
        end else begin
            m_el++;
        end
    endtask

    // One OneHz edge; the DUT reacts at the following clk edge.
    task automatic drive_tick(input bit side);
        @(posedge clk); #1;
        one_hz = ~one_hz;
        side_car = side;
        @(posedge clk); #1;
        model_tick(side);
    endtask

    task automatic idle(input int n, input bit wiggle);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (wiggle) side_car = 1'($urandom);
        end
    endtask

`ifdef PED_REQ_EN
    task automatic pulse_ped();
        @(posedge clk); #1 ped_req = 1'b1;
        @(posedge clk); #1 ped_req = 1'b0;
        m_ped = 1;
    endtask
`endif

    task automatic test_reset();
        rst_n = 1'b0; one_hz = 1'b1; side_car = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        runs++;
        if (act_vec !== {3'd5, 3'b100, 3'b100, 1'b0, CW'(TAR - 1)}) begin
            fails++; $display("FAIL reset_values: got %h expected %h", act_vec,
                              {3'd5, 3'b100, 3'b100, 1'b0, CW'(TAR - 1)});
        end
        rst_n = 1'b1;
        idle(6, 1'b0);
        runs++;
        if (act_vec !== exp_vec()) begin
            fails++; $display("FAIL reset_no_spurious_tick: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_startup();
        drive_tick(1'b0);
        runs++;
        if (main_l !== 3'b001 || side_l !== 3'b100 || act_vec !== exp_vec()) begin
            fails++; $display("FAIL startup: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_idle();
        for (int t = 1; t <= 40; t++) begin
            drive_tick(1'b0);
            idle($urandom_range(2, 8), 1'b0);
            runs++;
            if (act_vec !== exp_vec()) begin
                fails++; $display("FAIL idle tick %0d: got %h expected %h", t, act_vec, exp_vec());
            end
        end
        runs++;
        if (state !== 3'd0 || sec_left !== '0) begin
            fails++; $display("FAIL idle_hold: state %0d sec_left %0d, expected 0 0", state, sec_left);
        end
    endtask

    task automatic test_unlatched();
        idle(3, 1'b0);
        side_car = 1'b1;
        idle(5, 1'b0);
        side_car = 1'b0;
        idle(3, 1'b0);
        drive_tick(1'b0);
        runs++;
        if (state !== 3'd0 || act_vec !== exp_vec()) begin
            fails++; $display("FAIL unlatched_sensor: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_full_cycle();
        int last_entry = -1;
        int periods = 0;
        logic [2:0] prev;
        for (int t = 1; t <= 80; t++) begin
            prev = state;
            drive_tick(1'b1);
            runs++;
            if (act_vec !== exp_vec()) begin
                fails++; $display("FAIL full_cycle tick %0d: got %h expected %h", t, act_vec, exp_vec());
            end
            if (prev !== 3'd0 && state === 3'd0) begin
                if (last_entry >= 0) begin
                    periods++;
                    runs++;
                    if (t - last_entry !== 38) begin
                        fails++; $display("FAIL full_cycle_period: got %0d expected 38", t - last_entry);
                    end
                end
                last_entry = t;
            end
            idle($urandom_range(1, 4), 1'b0);
        end
        runs++;
        if (periods < 1) begin
            fails++; $display("FAIL full_cycle_period_seen: got %0d periods expected >=1", periods);
        end
    endtask

`ifdef PED_REQ_EN
    task automatic test_ped();
        int walk_ticks = 0;
        rst_n = 1'b0; #3 rst_n = 1'b1;
        model_reset();
        drive_tick(1'b0);
        for (int t = 1; t <= 45; t++) begin
            drive_tick(1'b0);
            if (t == 5) pulse_ped();
            idle($urandom_range(1, 4), 1'b0);
            if (walk === 1'b1) begin
                walk_ticks++;
                runs++;
                if (main_l !== 3'b100 || side_l !== 3'b100 || state !== 3'd6) begin
                    fails++; $display("FAIL ped_walk_heads: got %h expected state 6 all red", act_vec);
                end
            end
            runs++;
            if (act_vec !== exp_vec()) begin
                fails++; $display("FAIL ped tick %0d: got %h expected %h", t, act_vec, exp_vec());
            end
        end
        runs++;
        if (walk_ticks !== TW) begin
            fails++; $display("FAIL ped_walk_length: got %0d expected %0d", walk_ticks, TW);
        end
    endtask
`endif

    task automatic test_random();
        bit s;
        for (int t = 1; t <= 200; t++) begin
            s = ($urandom_range(0, 3) == 0);
            drive_tick(s);
            runs++;
            if (act_vec !== exp_vec()) begin
                fails++; $display("FAIL random tick %0d: got %h expected %h", t, act_vec, exp_vec());
            end
`ifdef PED_REQ_EN
            if ($urandom_range(0, 19) == 0) pulse_ped();
`endif
            idle($urandom_range(1, 6), 1'b1);
            runs++;
            if (act_vec !== exp_vec()) begin
                fails++; $display("FAIL random_frozen tick %0d: got %h expected %h", t, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 80 && m_ph != 3; i++) drive_tick(1'b1);
        runs++;
        if (state !== 3'd3) begin
            fails++; $display("FAIL mid_reset_reach_side_green: got %0d expected 3", state);
        end
        drive_tick(1'b1);
        idle(2, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        runs++;
        if (main_l !== 3'b100 || side_l !== 3'b100 || walk !== 1'b0 || state !== 3'd5) begin
            fails++; $display("FAIL mid_reset_immediate: got %h expected %h", act_vec, exp_vec());
        end
        one_hz = 1'b1;
        idle(3, 1'b0);
        rst_n = 1'b1;
        idle(8, 1'b0);
        runs++;
        if (act_vec !== exp_vec()) begin
            fails++; $display("FAIL mid_reset_no_tick: got %h expected %h", act_vec, exp_vec());
        end
        drive_tick(1'b0);
        runs++;
        if (state !== 3'd0 || act_vec !== exp_vec()) begin
            fails++; $display("FAIL mid_reset_resume: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_idle();
        test_unlatched();
        test_full_cycle();
`ifdef PED_REQ_EN
        test_ped();
`endif
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", runs, fails);
        $finish;
    end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Two-road intersection controller with a main and a side road. It sits directly downstream of the clock divider and consumes its `OneHz` square wave: each edge of `OneHz` is one elapsed second. It sequences the main and side signal heads through green, yellow and all-red phases with parameterised durations. Main road rests on green until the side-road sensor (or, optionally, a pedestrian request) demands service.

## Interface
Parameters:
- `T_MAIN_GREEN`, 20: minimum main green, seconds.
- `T_SIDE_GREEN`, 10: side green, seconds.
- `T_YELLOW`, 3: yellow, both roads, seconds.
- `T_ALL_RED`, 1: all-red clearance, seconds.
- `T_WALK`, 8: pedestrian walk, seconds (used only with `PED_REQ_EN`).
- `CNT_W`, 6: seconds counter width. Must hold the largest duration minus 1. Every duration must be ≥1.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `Sync_Reset_n` in 1: reset, asynchronous, active-low.
- `OneHz` in 1: divider output, synchronous to `clk`; toggles once per second.
- `Side_Car` in 1: side-road vehicle sensor, level, synchronous to `clk`, debounced upstream.
- `Ped_Req` in 1: pedestrian button pulse/level, synchronous to `clk` (present only with `PED_REQ_EN`).
- `Main_Lights` out 3: {R,Y,G}, one-hot.
- `Side_Lights` out 3: {R,Y,G}, one-hot.
- `Walk` out 1: pedestrian walk lamp.
- `State` out 3: current state code, for debug/LEDs.
- `Sec_Left` out `CNT_W`: seconds remaining in the current phase, minus 1.

## Operation
- **Tick generation:**
  - `OneHz_q` registers `OneHz`.
  - `tick = OneHz ^ OneHz_q`, high for exactly one `clk` cycle per `OneHz` edge.
- **States:** MAIN_GREEN, MAIN_YELLOW, ALL_RED_1, SIDE_GREEN, SIDE_YELLOW, ALL_RED_2, WALK.
- **Phase counting:**
  - On entering a state, the counter loads `T_x-1`.
  - The counter decrements by 1 on each tick.
  - The transition fires on a tick while the counter is 0, so each state lasts exactly `T_x` ticks.
- **Transitions:**
  - MAIN_GREEN→MAIN_YELLOW on tick with counter 0 **and** (`Side_Car` or `Ped_Pending`).
  - Otherwise MAIN_GREEN holds, the counter saturates at 0, and each later tick re-evaluates the condition.
  - `Side_Car` is sampled only on the deciding tick cycle; it is not latched.
  - MAIN_YELLOW→ALL_RED_1.
  - ALL_RED_1→WALK if `Ped_Pending`, else SIDE_GREEN.
  - SIDE_GREEN→SIDE_YELLOW→ALL_RED_2.
  - WALK→ALL_RED_2.
  - ALL_RED_2→MAIN_GREEN.
- **Light outputs:** decoded from the state register (Moore). All-red and WALK states drive both heads R. `Walk`=1 only in WALK.
- **Reset (async):**
  - State=ALL_RED_2, counter=`T_ALL_RED-1`.
  - `Main_Lights`=`Side_Lights`=3'b100, `Walk`=0, `State`=5.
  - `OneHz_q`=1, matching the divider's power-up value of 1, so no spurious tick.
  - `Ped_Pending`=0.
- **Reset mid-operation:** all outputs take their reset values immediately, and the current phase is abandoned.

## Timing
- `OneHz` edge at clk cycle n → tick high in cycle n+1.
- State, lights and counter update on the clk edge ending cycle n+1.
- Output latency from tick is 1 clk.
- Between ticks, state and counter are frozen.
- Full Side_Car cycle: 20+3+1+10+3+1 = 38 ticks.

## Configuration
- `PED_REQ_EN` defined:
  - `Ped_Req` port exists.
  - `Ped_Pending` sets on `Ped_Req`=1 and clears on the cycle of entry to WALK.
  - A request on the entry cycle is absorbed; requests during WALK re-latch for the next cycle.
- `PED_REQ_EN` undefined:
  - No `Ped_Req` port, and WALK is unreachable.
  - `Ped_Pending` is tied to 0 and `Walk` is tied to 0.

## Structure
- Package `traffic_pkg`:
  - State codes MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_1=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALL_RED_2=5, WALK=6.
  - Light encodings RED=3'b100, YELLOW=3'b010, GREEN=3'b001.
- Sub-module `sec_tick`: `OneHz` edge detector with async active-low reset, output `tick`.

## Test plan
- **Startup:** release reset, `OneHz` toggling every 10 clk, `Side_Car`=0 → 1 tick all-red, then `Main_Lights`=001, `Side_Lights`=100.
- **Idle main road:** `Side_Car`=0 for 40 ticks → MAIN_GREEN held, `Sec_Left`=0 from tick 20 onward.
- **Full cycle:** `Side_Car`=1 constant → main green 20, yellow 3, all-red 1, side green 10, side yellow 3, all-red 1, then main green; 38-tick period.
- **Unlatched sensor:** `Side_Car` pulsed for 5 clk away from a deciding tick → no transition.
- **Pedestrian (`PED_REQ_EN`):** one-cycle `Ped_Req` at tick 5 → after 20+3+1 ticks, WALK for 8 ticks with `Walk`=1 and both heads R, then ALL_RED_2, then MAIN_GREEN.
- **Mid-phase reset:** assert `Sync_Reset_n`=0 mid SIDE_GREEN → lights 100/100 immediately; release with `OneHz`=1 → no tick until the next `OneHz` edge.
